// File: rtl/simon_pkt_assembler_if.sv
`default_nettype none
// ============================================================================
//  Module   : simon_pkt_assembler_if
//  Purpose  : Bundles the byte stream, the packet bus and the loader
//             handshake that connect to simon_pkt_assembler.
//  Ports    : rxByte/rxValid/rxReady - incoming byte stream (valid/ready)
//             loadPkt                - loader status / acknowledge
//             newIN                  - packet on `in` valid (level)
//             in[P-1:0][7:0]         - assembled packet, P = N/2 + 2 bytes
//             pktDrop                - partial packet discarded (pulse)
//  Modports : master - byte source / packet loader side
//             slave  - assembler side
//  Revision : 1.0 - initial release
// ============================================================================
interface simon_pkt_assembler_if #(
   parameter int N = 16
);
   localparam int P = (N / 2) + 2;

   logic [7:0]        rxByte;
   logic              rxValid;
   logic              rxReady;
   logic              loadPkt;
   logic              newIN;
   logic [P-1:0][7:0] in;
   logic              pktDrop;

   modport master (
      output rxByte, rxValid, loadPkt,
      input  rxReady, newIN, in, pktDrop
   );

   modport slave (
      input  rxByte, rxValid, loadPkt,
      output rxReady, newIN, in, pktDrop
   );
endinterface
`default_nettype wire

// File: rtl/simon_pkt_assembler.sv
`default_nettype none
// ============================================================================
//  Module   : simon_pkt_assembler
//  Purpose  : Byte-serial packet assembler feeding the SIMON packet loader.
//             Bytes are collected into a fill buffer; a complete packet is
//             copied into the output register and offered with newIN until
//             the loader acknowledges it via loadPkt. The fill buffer can
//             assemble the next packet while the current one is offered.
//             A partial packet that stalls for TOUT idle cycles is dropped.
//  Ports    : clk  - system clock, rising edge
//             nR   - asynchronous active-low reset
//             bus  - simon_pkt_assembler_if.slave (stream, packet, handshake)
//  Revision : 1.0 - initial release
// ============================================================================
module simon_pkt_assembler #(
   parameter int N    = 16,
   parameter int TOUT = 255,
   parameter int CW   = 8
) (
   input  wire logic                 clk,
   input  wire logic                 nR,
   simon_pkt_assembler_if.slave      bus
);

   localparam int P  = (N / 2) + 2;
   localparam int IW = (P > 1) ? $clog2(P) : 1;

   localparam logic [IW-1:0] c_IDX_LAST = IW'(P - 1);
   localparam logic [CW-1:0] c_TMR_LAST = CW'(TOUT - 1);

   // Fill FSM encoding
   localparam logic [0:0] c_FILL  = 1'b0;
   localparam logic [0:0] c_FULL  = 1'b1;

   // Output FSM encoding
   localparam logic [1:0] c_EMPTY = 2'd0;
   localparam logic [1:0] c_OFFER = 2'd1;
   localparam logic [1:0] c_DRAIN = 2'd2;

   logic [0:0]        fill_st_q, fill_st_d;
   logic [1:0]        out_st_q,  out_st_d;
   logic [IW-1:0]     idx_q,     idx_d;
   logic [CW-1:0]     tmr_q,     tmr_d;
   logic [P-1:0][7:0] fill_q;
   logic [P-1:0][7:0] in_q;
   logic              drop_q;
   logic              run_q;

   logic              w_rx_ready;
   logic              w_new_in;
   logic              w_accept;
   logic              w_copy;
   logic              w_expire;

   assign w_accept = bus.rxValid && w_rx_ready;

   // Copy only when the offer slot is free; never coincides with an accept
   // because rxReady is low while the fill FSM sits in FULL.
   assign w_copy   = (fill_st_q == c_FULL) && (out_st_q == c_EMPTY);

   // An accept on the expiry cycle takes precedence over the drop.
   assign w_expire = (fill_st_q == c_FILL) && (idx_q != '0) &&
                     !w_accept && (tmr_q == c_TMR_LAST);

   // -------------------------------------------------------------------------
   // State and datapath registers
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge nR) begin
      if (!nR) begin
         fill_st_q <= c_FILL;
         out_st_q  <= c_EMPTY;
         idx_q     <= '0;
         tmr_q     <= '0;
         fill_q    <= '0;
         in_q      <= '0;
         drop_q    <= 1'b0;
         run_q     <= 1'b0;
      end else begin
         fill_st_q <= fill_st_d;
         out_st_q  <= out_st_d;
         idx_q     <= idx_d;
         tmr_q     <= tmr_d;
         drop_q    <= w_expire;
         // Holds rxReady low while reset is asserted and until the first edge
         run_q     <= 1'b1;
         if (w_accept) begin
            fill_q[idx_q] <= bus.rxByte;
         end
         if (w_copy) begin
            in_q <= fill_q;
         end
      end
   end

   // -------------------------------------------------------------------------
   // Fill FSM next state, byte index and inter-byte timer
   // -------------------------------------------------------------------------
   always_comb begin
      fill_st_d = fill_st_q;
      idx_d     = idx_q;
      tmr_d     = tmr_q;
      case (fill_st_q)
         c_FILL: begin
            if (w_accept) begin
               tmr_d = '0;
               if (idx_q == c_IDX_LAST) begin
                  idx_d     = '0;
                  fill_st_d = c_FULL;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end else if (idx_q != '0) begin
               if (w_expire) begin
                  idx_d = '0;
                  tmr_d = '0;
               end else begin
                  tmr_d = tmr_q + 1'b1;
               end
            end else begin
               // No packet in progress: nothing to time out
               tmr_d = '0;
            end
         end
         c_FULL: begin
            tmr_d = '0;
            if (w_copy) begin
               fill_st_d = c_FILL;
            end
         end
         default: begin
            fill_st_d = c_FILL;
            idx_d     = '0;
            tmr_d     = '0;
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // Output FSM next state
   // -------------------------------------------------------------------------
   always_comb begin
      out_st_d = out_st_q;
      case (out_st_q)
         c_EMPTY: begin
            // loadPkt is deliberately ignored here
            if (w_copy) begin
               out_st_d = c_OFFER;
            end
         end
         c_OFFER: begin
            if (bus.loadPkt) begin
               out_st_d = c_DRAIN;
            end
         end
         c_DRAIN: begin
            // Wait for loadPkt to fall so a long-held level is not seen as a
            // second acknowledge of the next packet.
            if (!bus.loadPkt) begin
               out_st_d = c_EMPTY;
            end
         end
         default: begin
            out_st_d = c_EMPTY;
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // FSM outputs
   // -------------------------------------------------------------------------
   always_comb begin
      w_rx_ready = (fill_st_q == c_FILL) && run_q;
      w_new_in   = (out_st_q == c_OFFER);
   end

   assign bus.rxReady = w_rx_ready;
   assign bus.newIN   = w_new_in;
   assign bus.in      = in_q;
   assign bus.pktDrop = drop_q;

endmodule
`default_nettype wire

// File: tb/tb_simon_pkt_assembler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_simon_pkt_assembler
//  Purpose  : Directed self-checking bench for simon_pkt_assembler (N=16,
//             TOUT=8). Inputs change just after the falling edge and outputs
//             are sampled there, half a cycle away from the active edge.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_simon_pkt_assembler;

   logic clk = 1'b0;
   logic nR  = 1'b0;
   int   checks   = 0;
   int   failures = 0;

   logic [9:0][7:0] exp_pkt;
   logic [9:0][7:0] hold_pkt;

   simon_pkt_assembler_if #(.N(16)) bus ();

   simon_pkt_assembler #(
      .N    (16),
      .TOUT (8),
      .CW   (8)
   ) dut (
      .clk (clk),
      .nR  (nR),
      .bus (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required finish earlier");
      $fatal(1, "watchdog");
   end

   // ------------------------------------------------------------------
   // Stimulus helpers (no comparisons apart from the bounded wait)
   // ------------------------------------------------------------------
   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Called just after a falling edge; returns just after the falling edge
   // that follows the accepting rising edge, so consecutive calls stream
   // bytes back to back.
   task automatic send_byte(input logic [7:0] b);
      int n;
      n = 0;
      bus.rxByte  = b;
      bus.rxValid = 1'b1;
      while (bus.rxReady !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (bus.rxReady !== 1'b1) begin
         failures++;
         $display("FAIL send_byte_wait: rxReady=%b required 1 within 200 cycles", bus.rxReady);
      end
      @(negedge clk);
      bus.rxValid = 1'b0;
   endtask

   task automatic ack_pkt();
      bus.loadPkt = 1'b1;
      idle(2);
      bus.loadPkt = 1'b0;
      idle(2);
   endtask

   function automatic logic [9:0][7:0] make_pkt(input logic [7:0] base);
      logic [9:0][7:0] p;
      for (int k = 0; k < 10; k++) p[k] = base + 8'(k);
      return p;
   endfunction

   // ------------------------------------------------------------------
   // Tests
   // ------------------------------------------------------------------
   task automatic test_reset();
      nR          = 1'b0;
      bus.rxByte  = 8'h00;
      bus.rxValid = 1'b0;
      bus.loadPkt = 1'b0;
      idle(2);
      checks++; if (bus.rxReady !== 1'b0) begin failures++; $display("FAIL reset_rxReady: got %b required 0", bus.rxReady); end
      checks++; if (bus.newIN !== 1'b0)   begin failures++; $display("FAIL reset_newIN: got %b required 0", bus.newIN); end
      checks++; if (bus.pktDrop !== 1'b0) begin failures++; $display("FAIL reset_pktDrop: got %b required 0", bus.pktDrop); end
      checks++; if (bus.in !== 80'h0)     begin failures++; $display("FAIL reset_in: got %h required 0", bus.in); end
      nR = 1'b1;
      idle(1);
      checks++; if (bus.rxReady !== 1'b1) begin failures++; $display("FAIL release_rxReady: got %b required 1", bus.rxReady); end
   endtask

   task automatic test_first_packet();
      exp_pkt = make_pkt(8'h01);
      for (int i = 0; i < 10; i++) send_byte(8'h01 + 8'(i));
      // one half-cycle after accept edge T: copy has not happened yet
      checks++; if (bus.newIN !== 1'b0)   begin failures++; $display("FAIL pkt1_newIN_early: got %b required 0", bus.newIN); end
      checks++; if (bus.rxReady !== 1'b0) begin failures++; $display("FAIL pkt1_rxReady_full: got %b required 0", bus.rxReady); end
      idle(1);
      checks++; if (bus.newIN !== 1'b1)   begin failures++; $display("FAIL pkt1_newIN: got %b required 1", bus.newIN); end
      checks++; if (bus.rxReady !== 1'b1) begin failures++; $display("FAIL pkt1_rxReady_back: got %b required 1", bus.rxReady); end
      checks++; if (bus.in[0] !== 8'h01)  begin failures++; $display("FAIL pkt1_in0: got %h required 01", bus.in[0]); end
      checks++; if (bus.in[8] !== 8'h09)  begin failures++; $display("FAIL pkt1_in8: got %h required 09", bus.in[8]); end
      checks++; if (bus.in[9] !== 8'h0A)  begin failures++; $display("FAIL pkt1_in9: got %h required 0A", bus.in[9]); end
      checks++; if (bus.in !== exp_pkt)   begin failures++; $display("FAIL pkt1_in: got %h required %h", bus.in, exp_pkt); end
   endtask

   task automatic test_hold_ack();
      for (int c = 0; c < 20; c++) begin
         idle(1);
         checks++;
         if (bus.newIN !== 1'b1 || bus.in !== exp_pkt) begin
            failures++;
            $display("FAIL hold_offer cycle %0d: newIN=%b in=%h required newIN=1 in=%h", c, bus.newIN, bus.in, exp_pkt);
         end
      end
      bus.loadPkt = 1'b1;
      idle(1);
      checks++; if (bus.newIN !== 1'b0) begin failures++; $display("FAIL ack_newIN: got %b required 0", bus.newIN); end
      idle(2);
      bus.loadPkt = 1'b0;
      for (int c = 0; c < 5; c++) begin
         idle(1);
         checks++;
         if (bus.newIN !== 1'b0 || bus.in !== exp_pkt) begin
            failures++;
            $display("FAIL post_ack cycle %0d: newIN=%b in=%h required newIN=0 in=%h", c, bus.newIN, bus.in, exp_pkt);
         end
      end
   endtask

   task automatic test_back_to_back();
      hold_pkt = make_pkt(8'h21);
      for (int i = 0; i < 10; i++) send_byte(8'h21 + 8'(i));
      idle(1);
      checks++; if (bus.newIN !== 1'b1 || bus.in !== hold_pkt) begin failures++; $display("FAIL b2b_first: newIN=%b in=%h required 1 %h", bus.newIN, bus.in, hold_pkt); end
      exp_pkt = make_pkt(8'h11);
      for (int i = 0; i < 10; i++) send_byte(8'h11 + 8'(i));
      idle(3);
      checks++; if (bus.rxReady !== 1'b0) begin failures++; $display("FAIL b2b_rxReady_wait: got %b required 0", bus.rxReady); end
      checks++; if (bus.newIN !== 1'b1 || bus.in !== hold_pkt) begin failures++; $display("FAIL b2b_first_held: newIN=%b in=%h required 1 %h", bus.newIN, bus.in, hold_pkt); end
      bus.loadPkt = 1'b1;
      idle(1);
      checks++; if (bus.newIN !== 1'b0) begin failures++; $display("FAIL b2b_ack_newIN: got %b required 0", bus.newIN); end
      idle(2);
      checks++; if (bus.newIN !== 1'b0 || bus.rxReady !== 1'b0) begin failures++; $display("FAIL b2b_drain: newIN=%b rxReady=%b required 0 0", bus.newIN, bus.rxReady); end
      bus.loadPkt = 1'b0;
      idle(1);   // DRAIN -> EMPTY edge
      checks++; if (bus.newIN !== 1'b0 || bus.in !== hold_pkt) begin failures++; $display("FAIL b2b_empty: newIN=%b in=%h required 0 %h", bus.newIN, bus.in, hold_pkt); end
      idle(1);   // copy edge
      checks++; if (bus.newIN !== 1'b1)   begin failures++; $display("FAIL b2b_copy_newIN: got %b required 1", bus.newIN); end
      checks++; if (bus.in !== exp_pkt)   begin failures++; $display("FAIL b2b_copy_in: got %h required %h", bus.in, exp_pkt); end
      checks++; if (bus.rxReady !== 1'b1) begin failures++; $display("FAIL b2b_copy_rxReady: got %b required 1", bus.rxReady); end
      ack_pkt();
   endtask

   task automatic test_timeout();
      send_byte(8'h55);
      send_byte(8'h56);
      send_byte(8'h57);
      for (int k = 1; k <= 10; k++) begin
         idle(1);
         checks++;
         if (bus.pktDrop !== (k == 8)) begin
            failures++;
            $display("FAIL timeout_pktDrop idle %0d: got %b required %b", k, bus.pktDrop, (k == 8));
         end
      end
      exp_pkt = make_pkt(8'hA0);
      for (int i = 0; i < 10; i++) send_byte(8'hA0 + 8'(i));
      idle(1);
      checks++; if (bus.newIN !== 1'b1 || bus.in !== exp_pkt) begin failures++; $display("FAIL timeout_next_pkt: newIN=%b in=%h required 1 %h", bus.newIN, bus.in, exp_pkt); end
      ack_pkt();
   endtask

   task automatic test_expiry_accept();
      send_byte(8'h61);
      send_byte(8'h62);
      send_byte(8'h63);
      for (int k = 1; k <= 7; k++) begin
         idle(1);
         checks++;
         if (bus.pktDrop !== 1'b0) begin failures++; $display("FAIL expiry_idle_pktDrop idle %0d: got %b required 0", k, bus.pktDrop); end
      end
      send_byte(8'h64);   // accepted on the 8th idle cycle
      checks++; if (bus.pktDrop !== 1'b0) begin failures++; $display("FAIL expiry_accept_pktDrop: got %b required 0", bus.pktDrop); end
      exp_pkt = make_pkt(8'h61);
      for (int i = 4; i < 10; i++) send_byte(8'h61 + 8'(i));
      idle(1);
      checks++; if (bus.newIN !== 1'b1 || bus.in !== exp_pkt) begin failures++; $display("FAIL expiry_pkt: newIN=%b in=%h required 1 %h", bus.newIN, bus.in, exp_pkt); end
      ack_pkt();
   endtask

   task automatic test_reset_mid();
      int drops;
      drops = 0;
      for (int i = 0; i < 5; i++) begin
         send_byte(8'h71 + 8'(i));
         idle($urandom_range(0, 4));
      end
      nR = 1'b0;
      #1;
      checks++; if (bus.rxReady !== 1'b0 || bus.newIN !== 1'b0 || bus.pktDrop !== 1'b0 || bus.in !== 80'h0) begin
         failures++; $display("FAIL midreset_outputs: rxReady=%b newIN=%b pktDrop=%b in=%h required all 0", bus.rxReady, bus.newIN, bus.pktDrop, bus.in);
      end
      idle(2);
      checks++; if (bus.rxReady !== 1'b0 || bus.newIN !== 1'b0 || bus.pktDrop !== 1'b0 || bus.in !== 80'h0) begin
         failures++; $display("FAIL midreset_held: rxReady=%b newIN=%b pktDrop=%b in=%h required all 0", bus.rxReady, bus.newIN, bus.pktDrop, bus.in);
      end
      nR = 1'b1;
      idle(1);
      checks++; if (bus.rxReady !== 1'b1) begin failures++; $display("FAIL midreset_release_rxReady: got %b required 1", bus.rxReady); end
      exp_pkt = make_pkt(8'h81);
      for (int i = 0; i < 10; i++) begin
         send_byte(8'h81 + 8'(i));
         if (i < 9) begin
            for (int g = $urandom_range(0, 5); g > 0; g--) begin
               idle(1);
               if (bus.pktDrop !== 1'b0) drops++;
            end
         end
      end
      checks++; if (drops != 0) begin failures++; $display("FAIL gaps_pktDrop: got %0d pulses required 0", drops); end
      idle(1);
      checks++; if (bus.newIN !== 1'b1 || bus.in !== exp_pkt) begin failures++; $display("FAIL midreset_pkt: newIN=%b in=%h required 1 %h", bus.newIN, bus.in, exp_pkt); end
      ack_pkt();
   endtask

   initial begin
      test_reset();
      test_first_packet();
      test_hold_ack();
      test_back_to_back();
      test_timeout();
      test_expiry_accept();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
